arbitro_mem_datos: RTL and testbench

Arbiter and sequencer for the MIPS data memory (single-port block RAM, byte-column write enables). It shares the RAM between the pipeline MEM stage and the debug unit. It generates per-column write enables and load extension for the pipeline. It also runs a debug dump that streams every word to the debug/UART side through a valid/ready handshake.

---
 rtl/arbitro_mem_datos.sv | 181 ++++++++++++++++++
 tb/tb_arbitro_mem_datos.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_mem_datos.sv
// Data-memory arbiter for the MIPS core: pipeline MEM stage has fixed priority over a debug dump sequencer.
// Optional misalignment detection is enabled by defining ARBITRO_MEM_DATOS_MISALIGN_DETECT_EN.
module arbitro_mem_datos #(
  parameter int RAM_WIDTH                       = 32,
  parameter int RAM_DEPTH                       = 1024,
  parameter int CANT_COLUMNAS_MEM_DATOS         = 4,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
  // Bits needed to index RAM_DEPTH-1, i.e. clogb2(RAM_DEPTH-1) for RAM_DEPTH >= 2.
  localparam int AW                             = $clog2(RAM_DEPTH)
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_pipe_read,
  input  logic                                       i_pipe_write,
  input  logic [AW+1:0]                              i_pipe_address,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_pipe_select_bytes,
  input  logic [RAM_WIDTH-1:0]                       i_pipe_data_write,
  output logic [RAM_WIDTH-1:0]                       o_pipe_data_read,
  input  logic                                       i_debug_start,
  input  logic                                       i_debug_ready,
  output logic                                       o_debug_valid,
  output logic [RAM_WIDTH-1:0]                       o_debug_data,
  output logic [AW-1:0]                              o_debug_address,
  output logic                                       o_debug_done,
  output logic                                       o_mem_enable,
  output logic [AW-1:0]                              o_mem_address,
  output logic [CANT_COLUMNAS_MEM_DATOS-1:0]         o_mem_write_enable,
  output logic [RAM_WIDTH-1:0]                       o_mem_data_write,
  input  logic [RAM_WIDTH-1:0]                       i_mem_data_read,
  output logic                                       o_error_misaligned
);

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {SZ_NONE = 2'd0, SZ_BYTE = 2'd1, SZ_HALF = 2'd2, SZ_WORD = 2'd3} size_t;
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_PRESENT, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [RAM_WIDTH-1:0]   dbg_data_q, dbg_data_d;
  logic                   dbg_rd;

  size_t                  size_q;
  logic                   zext_q;
  logic [1:0]             lsb_q;
  logic                   bad_q;

  size_t                  size;
  logic [1:0]             lsb;
  logic                   pipe_req;
  logic                   misaligned;

  assign size     = size_t'(i_pipe_select_bytes[1:0]);
  assign lsb      = i_pipe_address[1:0];
  assign pipe_req = i_pipe_read | i_pipe_write;

`ifdef ARBITRO_MEM_DATOS_MISALIGN_DETECT_EN
  logic err_q;

  assign misaligned = ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) err_q <= 1'b0;
    else if (pipe_req && misaligned) err_q <= 1'b1;
  end

  assign o_error_misaligned = err_q;
`else
  assign misaligned         = 1'b0;
  assign o_error_misaligned = 1'b0;
`endif

  // Column enables; a simultaneous read and write is served as a read only.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    o_mem_write_enable = '0;
    if (i_pipe_write && !i_pipe_read && !misaligned) begin
      unique case (size)
        SZ_WORD: o_mem_write_enable = '1;
        SZ_HALF: o_mem_write_enable = CANT_COLUMNAS_MEM_DATOS'(2'b11) << {lsb[1], 1'b0};
        SZ_BYTE: o_mem_write_enable = CANT_COLUMNAS_MEM_DATOS'(1) << lsb;
        SZ_NONE: o_mem_write_enable = '0;
      endcase
    end
  end

  assign o_mem_enable     = pipe_req | dbg_rd;
  assign o_mem_address    = pipe_req ? i_pipe_address[AW+1:2] : cnt_q;
  assign o_mem_data_write = i_pipe_data_write;

  // Load format is captured at issue because RAM data arrives one cycle later.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      size_q <= SZ_NONE;
      zext_q <= 1'b0;
      lsb_q  <= 2'b00;
      bad_q  <= 1'b0;
    end else if (i_pipe_read) begin
      size_q <= size;
      zext_q <= i_pipe_select_bytes[2];
      lsb_q  <= lsb;
      bad_q  <= misaligned;
    end
  end

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  assign byte_lane = i_mem_data_read[{lsb_q, 3'b000} +: BYTE_W];
  assign half_lane = i_mem_data_read[{lsb_q[1], 4'b0000} +: HALF_W];

  always_comb begin
    o_pipe_data_read = '0;
    if (!bad_q) begin
      unique case (size_q)
        SZ_WORD: o_pipe_data_read = i_mem_data_read;
        SZ_HALF: o_pipe_data_read = {{(RAM_WIDTH-HALF_W){~zext_q & half_lane[HALF_W-1]}}, half_lane};
        SZ_BYTE: o_pipe_data_read = {{(RAM_WIDTH-BYTE_W){~zext_q & byte_lane[BYTE_W-1]}}, byte_lane};
        SZ_NONE: o_pipe_data_read = '0;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dbg_data_d = dbg_data_q;
    dbg_rd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_debug_start) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!pipe_req) begin
          dbg_rd  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // RAM output here still reflects the address issued in READ.
        dbg_data_d = i_mem_data_read;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (i_debug_ready) begin
          if (cnt_q == AW'(RAM_DEPTH-1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_debug_valid   = (state_q == ST_PRESENT);
  assign o_debug_done    = (state_q == ST_DONE);
  assign o_debug_data    = dbg_data_q;
  assign o_debug_address = cnt_q;

endmodule

// File: tb/tb_arbitro_mem_datos.sv
// Self-checking bench for arbitro_mem_datos with a 4-word behavioural byte-column RAM.
// Expectations follow ARBITRO_MEM_DATOS_MISALIGN_DETECT_EN when it is defined.
module tb_arbitro_mem_datos;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int COLS  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pipe_read = 1'b0, pipe_write = 1'b0;
  logic [AW+1:0]   pipe_addr = '0;
  logic [2:0]      pipe_sel = '0;
  logic [W-1:0]    pipe_wd = '0;
  logic [W-1:0]    pipe_rd;
  logic            dbg_start = 1'b0, dbg_ready = 1'b0;
  logic            dbg_valid, dbg_done;
  logic [W-1:0]    dbg_data;
  logic [AW-1:0]   dbg_addr;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [COLS-1:0] mem_we;
  logic [W-1:0]    mem_wd, mem_rd;
  logic            err;

  always #5 clk = ~clk;

  arbitro_mem_datos #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .CANT_COLUMNAS_MEM_DATOS(COLS),
                      .CANT_BITS_SELECT_BYTES_MEM_DATA(3)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_pipe_read(pipe_read), .i_pipe_write(pipe_write), .i_pipe_address(pipe_addr),
    .i_pipe_select_bytes(pipe_sel), .i_pipe_data_write(pipe_wd), .o_pipe_data_read(pipe_rd),
    .i_debug_start(dbg_start), .i_debug_ready(dbg_ready), .o_debug_valid(dbg_valid),
    .o_debug_data(dbg_data), .o_debug_address(dbg_addr), .o_debug_done(dbg_done),
    .o_mem_enable(mem_en), .o_mem_address(mem_addr), .o_mem_write_enable(mem_we),
    .o_mem_data_write(mem_wd), .i_mem_data_read(mem_rd), .o_error_misaligned(err)
  );

  // Behavioural single-port RAM: read-before-write, one cycle read latency.
  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rd <= ram[mem_addr];
      for (int c = 0; c < COLS; c++)
        if (mem_we[c]) ram[mem_addr][8*c +: 8] <= mem_wd[8*c +: 8];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  logic [31:0] load_q [$];
  typedef struct packed { logic [AW-1:0] addr; logic [W-1:0] data; } dump_t;
  dump_t dump_q [$];
  logic [W-1:0] img [DEPTH];

  // Called at posedge+1; the write commits on the following edge.
  task automatic store(input logic [3:0] a, input logic [2:0] s, input logic [31:0] d,
                       input logic [3:0] exp_we, input string tag);
    pipe_write = 1'b1; pipe_read = 1'b0; pipe_addr = a; pipe_sel = s; pipe_wd = d;
    #1;
    check({tag, "_we"}, 32'(mem_we), 32'(exp_we));
    check({tag, "_en"}, 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    pipe_write = 1'b0;
  endtask

  // Issues one load and compares the extended result one cycle later.
  task automatic load(input logic [3:0] a, input logic [2:0] s, input logic [31:0] exp, input string tag);
    load_q.push_back(exp);
    pipe_read = 1'b1; pipe_addr = a; pipe_sel = s;
    @(posedge clk); #1;
    pipe_read = 1'b0; pipe_write = 1'b0;
    #1;
    check(tag, pipe_rd, load_q.pop_front());
  endtask

  task automatic run_dump(input int stall, input int ready_low, input int exp_done, input string tag);
    int          cyc = 0;
    int          done_cycle = -1;
    int          low_left = ready_low;
    int          unstable = 0;
    bit          first = 1'b1;
    logic [W-1:0] held = '0;
    dump_t       e;
    for (int i = 0; i < DEPTH; i++) dump_q.push_back({AW'(i), img[i]});
    while (cyc < 300 && done_cycle < 0) begin
      dbg_start = (cyc == 0) || (cyc == 7);
      dbg_ready = !(low_left > 0 && dbg_valid);
      pipe_read = (cyc >= 1 && cyc <= stall) || !dbg_ready;
      pipe_addr = 4'hC; pipe_sel = 3'b011;
      #1;
      if (dbg_done) done_cycle = cyc;
      else if (dbg_valid && !dbg_ready) begin
        if (first) begin held = dbg_data; first = 1'b0; end
        else if (dbg_data !== held) unstable++;
        low_left--;
      end else if (dbg_valid) begin
        check({tag, "_q_nonempty"}, 32'(dump_q.size() != 0), 32'd1);
        if (dump_q.size() != 0) begin
          e = dump_q.pop_front();
          check({tag, "_addr"}, 32'(dbg_addr), 32'(e.addr));
          check({tag, "_data"}, dbg_data, e.data);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    dbg_start = 1'b0; pipe_read = 1'b0; dbg_ready = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cycle), 32'(exp_done));
    check({tag, "_words_left"}, 32'(dump_q.size()), 32'd0);
    check({tag, "_done_one_cycle"}, 32'(dbg_done), 32'd0);
    if (ready_low > 0) begin
      check({tag, "_hold_stable"}, 32'(unstable), 32'd0);
      check({tag, "_low_cycles"}, 32'(ready_low - low_left), 32'(ready_low));
    end
    dump_q.delete();
  endtask

  initial begin
    int seen_done, seen_valid, seen_en;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(dbg_valid), 32'd0);
    check("rst_done", 32'(dbg_done), 32'd0);
    check("rst_data", dbg_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    store(4'h0, 3'b011, 32'h0000_0000, 4'b1111, "st_w0");
    store(4'h2, 3'b010, 32'h1234_0000, 4'b1100, "st_half2");
    store(4'h4, 3'b011, 32'h5555_5555, 4'b1111, "st_w1");
    pipe_write = 1'b1; pipe_addr = 4'h6; pipe_sel = 3'b001; pipe_wd = 32'h00AB_0000;
    #1;
    check("st_byte6_addr", 32'(mem_addr), 32'd1);
    @(posedge clk); #1;
    pipe_write = 1'b0;
    store(4'h6, 3'b001, 32'h00AB_0000, 4'b0100, "st_byte6");
    store(4'h8, 3'b011, 32'h80FF_FFFF, 4'b1111, "st_w2");
    store(4'hC, 3'b011, 32'hCAFE_F00D, 4'b1111, "st_w3");
    img[0] = 32'h1234_0000; img[1] = 32'h55AB_5555; img[2] = 32'h80FF_FFFF; img[3] = 32'hCAFE_F00D;

    load(4'h0, 3'b011, 32'h1234_0000, "ld_word0");
    load(4'hB, 3'b001, 32'hFFFF_FF80, "ld_byte_s");
    load(4'hB, 3'b101, 32'h0000_0080, "ld_byte_z");
    load(4'h8, 3'b010, 32'hFFFF_FFFF, "ld_half_s_lo");
    load(4'hA, 3'b110, 32'h0000_80FF, "ld_half_z_hi");
    load(4'hA, 3'b010, 32'hFFFF_80FF, "ld_half_s_hi");
    load(4'h6, 3'b001, 32'hFFFF_FFAB, "ld_byte_s6");
    load(4'h4, 3'b101, 32'h0000_0055, "ld_byte_z4");
    load(4'hC, 3'b011, 32'hCAFE_F00D, "ld_word3");
    load(4'h4, 3'b000, 32'h0000_0000, "ld_none");

    pipe_write = 1'b1; pipe_read = 1'b1; pipe_addr = 4'h4; pipe_sel = 3'b011; pipe_wd = 32'hDEAD_BEEF;
    #1;
    check("rw_both_we", 32'(mem_we), 32'd0);
    load(4'h4, 3'b011, 32'h55AB_5555, "rw_both_ld");

    run_dump(0, 0, 13, "dump");
    run_dump(5, 0, 18, "dump_stall");
    run_dump(0, 10, 23, "dump_hold");

    dbg_ready = 1'b1; dbg_start = 1'b1;
    @(posedge clk); #1;
    dbg_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(dbg_valid), 32'd0);
    check("midrst_data", dbg_data, 32'd0);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 0; seen_valid = 0; seen_en = 0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_done) seen_done++;
      if (dbg_valid) seen_valid++;
      if (mem_en) seen_en++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_no_valid", 32'(seen_valid), 32'd0);
    check("midrst_idle", 32'(seen_en), 32'd0);

`ifdef ARBITRO_MEM_DATOS_MISALIGN_DETECT_EN
    store(4'h1, 3'b010, 32'h0000_BEEF, 4'b0000, "mis_half");
    check("mis_err_set", 32'(err), 32'd1);
    load(4'h2, 3'b011, 32'h0000_0000, "mis_word_ld");
    repeat (5) @(posedge clk);
    #1;
    check("mis_err_held", 32'(err), 32'd1);
    load(4'h0, 3'b011, 32'h1234_0000, "mis_ram_kept");
    rst_n = 1'b0;
    #1;
    check("mis_err_rst", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
`else
    store(4'h1, 3'b010, 32'h0000_BEEF, 4'b0011, "mis_half");
    check("mis_err_tied", 32'(err), 32'd0);
    load(4'h2, 3'b011, 32'h1234_BEEF, "mis_word_ld");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
